// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back path.
package regfile_pkg;

    localparam int unsigned N_DEFAULT  = 32;
    localparam int unsigned R_DEFAULT  = 5;
    localparam int unsigned CW_DEFAULT = 16;
    localparam int unsigned ZERO_REG   = 0;

    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } wb_src_t;

    // The requester that is not s; used to hand priority to the loser.
    function automatic wb_src_t other_src(input wb_src_t s);
        return (s == REQ_ALU) ? REQ_LOAD : REQ_ALU;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Requester-side valid/ready bundle for the two write-back sources.
interface regfile_wb_arbiter_if #(
    parameter int unsigned n = 32,
    parameter int unsigned r = 5
);
    logic [1:0]   req_valid;
    logic [r-1:0] req_addr0;
    logic [r-1:0] req_addr1;
    logic [n-1:0] req_data0;
    logic [n-1:0] req_data1;
    logic [1:0]   req_ready;

    modport master (
        output req_valid, req_addr0, req_addr1, req_data0, req_data1,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_addr0, req_addr1, req_data0, req_data1,
        output req_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; owns the priority flop, grant is combinational.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant_c,
    output wb_src_t    o_winner_c,
    output logic       o_conflict_c
);

    wb_src_t    r_prio;
    logic [1:0] w_valid;

    assign w_valid      = i_en ? i_valid : 2'b00;
    assign o_conflict_c = &w_valid;

    always_comb begin
        o_grant_c  = 2'b00;
        o_winner_c = REQ_ALU;
        case (w_valid)
            2'b01: begin
                o_grant_c  = 2'b01;
                o_winner_c = REQ_ALU;
            end
            2'b10: begin
                o_grant_c  = 2'b10;
                o_winner_c = REQ_LOAD;
            end
            2'b11: begin
                if (r_prio == REQ_LOAD) begin
                    o_grant_c  = 2'b10;
                    o_winner_c = REQ_LOAD;
                end else begin
                    o_grant_c  = 2'b01;
                    o_winner_c = REQ_ALU;
                end
            end
            default: ;
        endcase
    end

    // Every handshake passes priority to the requester that did not win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= REQ_ALU;
        end else if (|o_grant_c) begin
            r_prio <= other_src(o_winner_c);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU and load write-back with a
// registered output stage, register-0 suppression and a conflict counter.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned n  = N_DEFAULT,
    parameter int unsigned r  = R_DEFAULT,
    parameter int unsigned cw = CW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus,
    output logic [r-1:0]         write_addr,
    output logic [n-1:0]         write_data,
    output logic                 write_en,
    output logic [cw-1:0]        conflict_cnt,
    output wb_src_t              last_grant
);

    logic          r_run;
    logic [r-1:0]  r_write_addr;
    logic [n-1:0]  r_write_data;
    logic          r_write_en;
    logic [cw-1:0] r_conflict_cnt;
    wb_src_t       r_last_grant;

    logic [1:0]    w_grant_c;
    wb_src_t       w_winner_c;
    logic          w_conflict_c;
    logic          w_hs;
    logic          w_wr;
    logic [r-1:0]  w_addr;
    logic [n-1:0]  w_data;

    // Grants stay off until the first rising edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    rr_arb2 u_arb (
        .clk          (clk),
        .rst_n        (rst),
        .i_en         (r_run),
        .i_valid      (bus.req_valid),
        .o_grant_c    (w_grant_c),
        .o_winner_c   (w_winner_c),
        .o_conflict_c (w_conflict_c)
    );

    assign bus.req_ready = w_grant_c;
    assign w_hs   = |w_grant_c;
    assign w_addr = (w_winner_c == REQ_LOAD) ? bus.req_addr1 : bus.req_addr0;
    assign w_data = (w_winner_c == REQ_LOAD) ? bus.req_data1 : bus.req_data0;
    assign w_wr   = w_hs && (w_addr != r'(ZERO_REG));

    // Register-0 requests still handshake but never reach the write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_write_en     <= 1'b0;
            r_write_addr   <= '0;
            r_write_data   <= '0;
            r_last_grant   <= REQ_ALU;
            r_conflict_cnt <= '0;
        end else begin
            r_write_en <= w_wr;
            if (w_wr) begin
                r_write_addr <= w_addr;
                r_write_data <= w_data;
            end
            if (w_hs) begin
                r_last_grant <= w_winner_c;
            end
            if (w_conflict_c && (r_conflict_cnt != {cw{1'b1}})) begin
                r_conflict_cnt <= r_conflict_cnt + cw'(1);
            end
        end
    end

    assign write_en     = r_write_en;
    assign write_addr   = r_write_addr;
    assign write_data   = r_write_data;
    assign last_grant   = r_last_grant;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus reset,
// regfile read-back and counter saturation sequences.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic clk;
    logic rst;

    regfile_wb_arbiter_if #(.n(32), .r(5)) bus ();
    regfile_wb_arbiter_if #(.n(32), .r(5)) sbus ();

    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        write_en;
    logic [15:0] conflict_cnt;
    wb_src_t     last_grant;

    logic [4:0]  s_write_addr;
    logic [31:0] s_write_data;
    logic        s_write_en;
    logic [1:0]  s_conflict_cnt;
    wb_src_t     s_last_grant;

    regfile_wb_arbiter #(.n(32), .r(5), .cw(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_en     (write_en),
        .conflict_cnt (conflict_cnt),
        .last_grant   (last_grant)
    );

    regfile_wb_arbiter #(.n(32), .r(5), .cw(2)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .bus          (sbus),
        .write_addr   (s_write_addr),
        .write_data   (s_write_data),
        .write_en     (s_write_en),
        .conflict_cnt (s_conflict_cnt),
        .last_grant   (s_last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple regfile model fed by the write port.
    logic [31:0] rf [32];
    always @(posedge clk) begin
        if (write_en) rf[write_addr] <= write_data;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
        bus.req_valid = v;
        bus.req_addr0 = a0;
        bus.req_data0 = d0;
        bus.req_addr1 = a1;
        bus.req_data1 = d1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [1:0]  rdy;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        lg;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{2'b11, 5'd5, 32'h15, 5'd6, 32'h23, 2'b01, 1'b1, 5'd5, 32'h15, 1'b0, 16'd1};
        tbl[1] = '{2'b11, 5'd5, 32'h16, 5'd6, 32'h23, 2'b10, 1'b1, 5'd6, 32'h23, 1'b1, 16'd2};
        tbl[2] = '{2'b11, 5'd5, 32'h16, 5'd6, 32'h24, 2'b01, 1'b1, 5'd5, 32'h16, 1'b0, 16'd3};
        tbl[3] = '{2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  2'b00, 1'b0, 5'd5, 32'h16, 1'b0, 16'd3};
        tbl[4] = '{2'b10, 5'd0, 32'h0,  5'd0, 32'hFF, 2'b10, 1'b0, 5'd5, 32'h16, 1'b1, 16'd3};
        tbl[5] = '{2'b01, 5'd6, 32'hA7, 5'd0, 32'h0,  2'b01, 1'b1, 5'd6, 32'hA7, 1'b0, 16'd3};
        tbl[6] = '{2'b10, 5'd0, 32'h0,  5'd9, 32'h12345678, 2'b10, 1'b1, 5'd9, 32'h12345678, 1'b1, 16'd3};
        tbl[7] = '{2'b11, 5'd0, 32'hDEAD, 5'd3, 32'h33, 2'b01, 1'b0, 5'd9, 32'h12345678, 1'b0, 16'd4};
        tbl[8] = '{2'b11, 5'd7, 32'h77, 5'd3, 32'h33, 2'b10, 1'b1, 5'd3, 32'h33, 1'b1, 16'd5};
        tbl[9] = '{2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  2'b00, 1'b0, 5'd3, 32'h33, 1'b1, 16'd5};

        rst = 1'b0;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        sbus.req_valid = 2'b00;
        sbus.req_addr0 = 5'd1;
        sbus.req_data0 = 32'h1;
        sbus.req_addr1 = 5'd2;
        sbus.req_data1 = 32'h2;

        step();
        chk("rst_we",   32'(write_en), 32'd0);
        chk("rst_addr", 32'(write_addr), 32'd0);
        chk("rst_data", write_data, 32'd0);
        chk("rst_cnt",  32'(conflict_cnt), 32'd0);
        chk("rst_last", 32'(last_grant), 32'd0);
        step();
        rst = 1'b1;
        step();

        // Vector table: ready checked mid-cycle, registered outputs after the edge.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1);
            #2;
            chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].rdy));
            step();
            chk($sformatf("v%0d_we", i),   32'(write_en), 32'(tbl[i].we));
            chk($sformatf("v%0d_addr", i), 32'(write_addr), 32'(tbl[i].wa));
            chk($sformatf("v%0d_data", i), write_data, tbl[i].wd);
            chk($sformatf("v%0d_last", i), 32'(last_grant), 32'(tbl[i].lg));
            chk($sformatf("v%0d_cnt", i),  32'(conflict_cnt), 32'(tbl[i].cnt));
        end

        // Single write reaches the regfile one edge after the output stage.
        drive(2'b01, 5'd6, 32'hB8, 5'd0, 32'h0);
        #2;
        chk("rf_ready", 32'(bus.req_ready), 32'h1);
        step();
        chk("rf_we", 32'(write_en), 32'd1);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        step();
        chk("rf_read6", rf[6], 32'hB8);
        chk("rf_we_off", 32'(write_en), 32'd0);

        // Saturating counter with cw=2.
        sbus.req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("sat_cnt%0d", i), 32'(s_conflict_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        sbus.req_valid = 2'b00;

        // Asynchronous reset while a write is pending.
        drive(2'b01, 5'd4, 32'h44, 5'd0, 32'h0);
        #2;
        chk("mr_ready0", 32'(bus.req_ready), 32'h1);
        step();
        chk("mr_we_pre", 32'(write_en), 32'd1);
        drive(2'b11, 5'd8, 32'h88, 5'd2, 32'h22);
        #1;
        rst = 1'b0;
        #1;
        chk("mr_we",    32'(write_en), 32'd0);
        chk("mr_addr",  32'(write_addr), 32'd0);
        chk("mr_data",  write_data, 32'd0);
        chk("mr_cnt",   32'(conflict_cnt), 32'd0);
        chk("mr_last",  32'(last_grant), 32'd0);
        chk("mr_ready", 32'(bus.req_ready), 32'd0);
        step();
        chk("mr_ready_hold", 32'(bus.req_ready), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("mr_ready_rel", 32'(bus.req_ready), 32'd0);
        step();
        chk("mr_ready_run", 32'(bus.req_ready), 32'h1);
        chk("mr_we_idle", 32'(write_en), 32'd0);
        step();
        chk("mr_we_post",   32'(write_en), 32'd1);
        chk("mr_addr_post", 32'(write_addr), 32'd8);
        chk("mr_data_post", write_data, 32'h88);
        chk("mr_cnt_post",  32'(conflict_cnt), 32'd1);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
